debug_trace_tx: RTL and testbench
=================================

DEBUG_TRACE_TX -- requirements
Module: debug_trace_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clocks per UART bit (100 MHz / 115200).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the number of buffered trace records (power of two, >= 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sample_en, input, 1 bit: capture strobe; dbg_in1..3 are sampled on each clk edge where it is high.
REQ-006 The block SHALL have ports dbg_in1, dbg_in2 and dbg_in3, input, 8 bits each: PC byte, register read byte and code-word byte, in that order.
REQ-007 The block SHALL have port tx, output, 1 bit: UART serial line, 8N1, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a frame is on the line or the FIFO is non-empty.
REQ-009 The block SHALL have port overflow, output, 1 bit: sticky flag set when a sample is dropped.
REQ-010 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current count of buffered records.

Function
REQ-011 A record SHALL be the 24-bit value {dbg_in3, dbg_in2, dbg_in1} as captured on a sample_en edge.
REQ-012 Each record SHALL be sent as 4 bytes, in order: sync 0xA5, dbg_in1, dbg_in2, dbg_in3.
REQ-013 Each byte SHALL be framed as start bit (0), 8 data bits LSB first, stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-014 The transmit FSM SHALL have states IDLE, START, DATA, STOP, with a 2-bit byte index 0..3 and a 3-bit bit index 0..7.
- IDLE→START when the FIFO is non-empty; the FIFO is popped in the same cycle.
- START→DATA, DATA(bit 7)→STOP, STOP→START (next byte index), each after CLKS_PER_BIT cycles.
- STOP of byte 3 goes to START if the FIFO is non-empty (popping it), else to IDLE; there is no idle gap between back-to-back records.
REQ-015 Latency: with the FIFO empty and the FSM in IDLE, sample_en high at edge N SHALL give fifo_level=1 after edge N and tx=0 after edge N+1.
REQ-016 A record SHALL occupy exactly 40*CLKS_PER_BIT cycles on tx.
REQ-017 A push when fifo_level==FIFO_DEPTH SHALL be dropped and overflow set, except when a pop occurs the same cycle; then the push SHALL be accepted.
REQ-018 Simultaneous push and pop with a non-full FIFO SHALL leave fifo_level unchanged.
REQ-019 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL never exceed FIFO_DEPTH.
REQ-020 overflow SHALL clear only on reset.
REQ-021 tx SHALL be registered (glitch-free) and held 1 in IDLE.

Reset
REQ-022 Reset SHALL apply asynchronously on resetn low: tx=1, busy=0, overflow=0, fifo_level=0, FSM=IDLE, all counters and pointers 0.
REQ-023 Reset mid-frame SHALL force tx=1 immediately and flush the FIFO; no partial frame resumes after release.
REQ-024 sample_en SHALL be ignored while resetn is low; the first capture is on the first edge after release.

Structure
REQ-025 Package debug_trace_pkg SHALL hold SYNC_BYTE (8'hA5), the FSM state enum and the record width (24).
REQ-026 The FIFO SHALL be the sub-module trace_fifo (parameterised width/depth, with push, pop, full, empty and level signals); UART framing and the FSM stay in debug_trace_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 Single sample test: one sample_en with dbg_in1..3 = 0x03, 0xE7, 0xA0 → tx decodes bytes A5 03 E7 A0; tx is low one edge after fifo_level=1; busy drops after 160 cycles.
REQ-028 Burst test: 3 consecutive sample_en (PC 0x00, 0x01, 0x02) → 12 bytes sent with no idle gap between records; fifo_level peaks at 2 (one record already popped); overflow=0.
REQ-029 Overflow test: 6 consecutive samples while the first record is transmitting → 5 records sent, 1 dropped, overflow=1 and held until reset.
REQ-030 Full plus pop test: push on the exact cycle the FSM pops from a full FIFO → push accepted, fifo_level stays 4, overflow=0.
REQ-031 Reset test: resetn low during the DATA state of byte 2 → tx=1 asynchronously, fifo_level=0; after release, the next sample produces a clean A5-led record.

Source files
------------

// File: rtl/debug_trace_pkg.sv
// Shared constants, FSM state type and byte selection for the debug trace UART.
package debug_trace_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned REC_W     = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Byte 0 is the sync marker, bytes 1..3 are dbg_in1..dbg_in3.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                            input logic [REC_W-1:0] rec);
    logic [7:0] b;
    case (idx)
      2'd0:    b = SYNC_BYTE;
      2'd1:    b = rec[7:0];
      2'd2:    b = rec[15:8];
      default: b = rec[23:16];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding trace records; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module trace_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/debug_trace_tx.sv
// Buffers 24-bit debug samples and streams each as four 8N1 UART bytes:
// sync 0xA5, dbg_in1, dbg_in2, dbg_in3.
module debug_trace_tx
  import debug_trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          sample_en,
  input  logic [7:0]                    dbg_in1,
  input  logic [7:0]                    dbg_in2,
  input  logic [7:0]                    dbg_in3,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned        CW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]      CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e         state, state_n;
  logic [1:0]        byte_idx, byte_n;
  logic [2:0]        bit_idx, bit_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [REC_W-1:0]  rec, rec_n;
  logic [REC_W-1:0]  fifo_dout;
  logic              fifo_full, fifo_empty;
  logic              pop;
  logic              last;
  logic              tx_n;
  logic [7:0]        cur_byte;

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (sample_en),
    .pop    (pop),
    .din    ({dbg_in3, dbg_in2, dbg_in1}),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign busy = (state != IDLE) || !fifo_empty;
  assign last = (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    byte_n  = byte_idx;
    bit_n   = bit_idx;
    cnt_n   = cnt;
    rec_n   = rec;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          rec_n   = fifo_dout;
          state_n = START;
          byte_n  = '0;
          bit_n   = '0;
          cnt_n   = '0;
        end
      end
      START: begin
        if (last) begin
          state_n = DATA;
          bit_n   = '0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (last) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (last) begin
          cnt_n = '0;
          if (byte_idx == 2'd3) begin
            byte_n = '0;
            // Chain straight into the next record so there is no idle gap.
            if (!fifo_empty) begin
              pop     = 1'b1;
              rec_n   = fifo_dout;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            byte_n  = byte_idx + 2'd1;
            state_n = START;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // tx is computed from the next state so the line moves on the same edge as
  // the FSM while still coming straight out of a flop.
  always_comb begin
    cur_byte = frame_byte(byte_n, rec_n);
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_byte[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      byte_idx <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
      rec      <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      byte_idx <= byte_n;
      bit_idx  <= bit_n;
      cnt      <= cnt_n;
      rec      <= rec_n;
      tx       <= tx_n;
      if (sample_en && fifo_full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_debug_trace_tx.sv
// Directed bench for debug_trace_tx with 4 clocks per bit and a 4-deep FIFO.
module tb_debug_trace_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sample_en = 1'b0;
  logic [7:0] dbg_in1 = '0;
  logic [7:0] dbg_in2 = '0;
  logic [7:0] dbg_in3 = '0;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_level;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned t_push;
  int unsigned t_end;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debug_trace_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sample_en  (sample_en),
    .dbg_in1    (dbg_in1),
    .dbg_in2    (dbg_in2),
    .dbg_in3    (dbg_in3),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called with the line at some cycle of data bit 0; samples each bit once.
  task automatic rx_body(output logic [7:0] b);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[i] = tx;
      repeat (CPB) @(negedge clk);
    end
    chk("rx_stop_bit", 32'(tx), 32'd1);
  endtask

  task automatic rx_byte(output logic [7:0] b);
    int unsigned n;
    n = 0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rx_start_bit", 32'(tx), 32'd0);
    repeat (CPB) @(negedge clk);
    rx_body(b);
  endtask

  task automatic rx_rec(input string tag, input logic in_data,
                        input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] b;
    if (in_data) rx_body(b);
    else         rx_byte(b);
    chk({tag, "_sync"}, 32'(b), 32'hA5);
    rx_byte(b); chk({tag, "_b1"}, 32'(b), 32'(e1));
    rx_byte(b); chk({tag, "_b2"}, 32'(b), 32'(e2));
    rx_byte(b); chk({tag, "_b3"}, 32'(b), 32'(e3));
  endtask

  task automatic wait_idle(input int unsigned limit, output int unsigned t);
    int unsigned n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("busy_drop", 32'(busy), 32'd0);
    t = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] lv5 [5];
    logic [2:0] lv6 [6];
    logic       ov6 [6];
    lv5 = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    lv6 = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    ov6 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single sample: level 1 after the capture edge, start bit one edge later
    dbg_in1 = 8'h03; dbg_in2 = 8'hE7; dbg_in3 = 8'hA0; sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    t_push = cyc;
    chk("single_level1", 32'(fifo_level), 32'd1);
    chk("single_tx_idle", 32'(tx), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("single_tx_start", 32'(tx), 32'd0);
    chk("single_level0", 32'(fifo_level), 32'd0);
    rx_rec("single", 1'b0, 8'h03, 8'hE7, 8'hA0);
    wait_idle(400, t_end);
    chk("single_len", t_end - t_push, 32'd161);
    chk("single_tx_high", 32'(tx), 32'd1);

    // Burst of three back-to-back samples
    repeat (3) @(negedge clk);
    dbg_in1 = 8'h00; dbg_in2 = 8'h10; dbg_in3 = 8'h20; sample_en = 1'b1;
    @(negedge clk);
    t_push = cyc;
    chk("burst_lvl_a", 32'(fifo_level), 32'd1);
    dbg_in1 = 8'h01; dbg_in2 = 8'h11; dbg_in3 = 8'h21;
    @(negedge clk);
    chk("burst_lvl_b", 32'(fifo_level), 32'd1);
    dbg_in1 = 8'h02; dbg_in2 = 8'h12; dbg_in3 = 8'h22;
    @(negedge clk);
    chk("burst_lvl_c", 32'(fifo_level), 32'd2);
    sample_en = 1'b0;
    @(negedge clk);
    chk("burst_lvl_d", 32'(fifo_level), 32'd2);
    chk("burst_ovf", 32'(overflow), 32'd0);
    rx_rec("burst0", 1'b0, 8'h00, 8'h10, 8'h20);
    rx_rec("burst1", 1'b0, 8'h01, 8'h11, 8'h21);
    rx_rec("burst2", 1'b0, 8'h02, 8'h12, 8'h22);
    wait_idle(1000, t_end);
    chk("burst_len", t_end - t_push, 32'd481);
    chk("burst_ovf_end", 32'(overflow), 32'd0);

    // Push on the exact edge the FSM pops from a full FIFO
    repeat (3) @(negedge clk);
    dbg_in2 = 8'h77; dbg_in3 = 8'h88; sample_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dbg_in1 = 8'(8'h30 + i);
      @(negedge clk);
      if (i == 0) t_push = cyc;
      chk("fullpop_fill_lvl", 32'(fifo_level), 32'(lv5[i]));
    end
    sample_en = 1'b0;
    repeat (156) @(negedge clk);
    chk("fullpop_pre_lvl", 32'(fifo_level), 32'd4);
    chk("fullpop_pre_tx", 32'(tx), 32'd1);
    dbg_in1 = 8'h35; sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    chk("fullpop_cyc", cyc - t_push, 32'd161);
    chk("fullpop_lvl", 32'(fifo_level), 32'd4);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    chk("fullpop_tx_start", 32'(tx), 32'd0);
    wait_idle(1200, t_end);
    chk("fullpop_len", t_end - t_push, 32'd961);
    chk("fullpop_ovf_end", 32'(overflow), 32'd0);

    // Six samples while the first record is transmitting; the sixth is dropped
    repeat (3) @(negedge clk);
    sample_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dbg_in1 = 8'(8'h40 + i); dbg_in2 = 8'(8'h50 + i); dbg_in3 = 8'(8'h60 + i);
      @(negedge clk);
      if (i == 0) t_push = cyc;
      chk("ovf_lvl", 32'(fifo_level), 32'(lv6[i]));
      chk("ovf_flag", 32'(overflow), 32'(ov6[i]));
    end
    sample_en = 1'b0;
    rx_rec("ovf0", 1'b1, 8'h40, 8'h50, 8'h60);
    rx_rec("ovf1", 1'b0, 8'h41, 8'h51, 8'h61);
    rx_rec("ovf2", 1'b0, 8'h42, 8'h52, 8'h62);
    rx_rec("ovf3", 1'b0, 8'h43, 8'h53, 8'h63);
    rx_rec("ovf4", 1'b0, 8'h44, 8'h54, 8'h64);
    wait_idle(1200, t_end);
    chk("ovf_len", t_end - t_push, 32'd801);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_lvl_end", 32'(fifo_level), 32'd0);

    // Reset during DATA of byte 2, with a second record still queued
    repeat (3) @(negedge clk);
    dbg_in1 = 8'h11; dbg_in2 = 8'h00; dbg_in3 = 8'h33; sample_en = 1'b1;
    @(negedge clk);
    t_push = cyc;
    dbg_in1 = 8'h12;
    @(negedge clk);
    sample_en = 1'b0;
    repeat (89) @(negedge clk);
    chk("rstmid_cyc", cyc - t_push, 32'd90);
    chk("rstmid_tx_low", 32'(tx), 32'd0);
    chk("rstmid_lvl", 32'(fifo_level), 32'd1);
    chk("rstmid_ovf_held", 32'(overflow), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rstmid_tx_async", 32'(tx), 32'd1);
    chk("rstmid_lvl_async", 32'(fifo_level), 32'd0);
    chk("rstmid_busy_async", 32'(busy), 32'd0);
    chk("rstmid_ovf_clr", 32'(overflow), 32'd0);
    dbg_in1 = 8'h5A; dbg_in2 = 8'hC3; dbg_in3 = 8'h0F; sample_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rsthold_lvl", 32'(fifo_level), 32'd0);
    chk("rsthold_tx", 32'(tx), 32'd1);
    resetn = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    t_push = cyc;
    chk("post_rst_lvl", 32'(fifo_level), 32'd1);
    @(negedge clk);
    chk("post_rst_tx_start", 32'(tx), 32'd0);
    rx_rec("post_rst", 1'b0, 8'h5A, 8'hC3, 8'h0F);
    wait_idle(400, t_end);
    chk("post_rst_len", t_end - t_push, 32'd161);
    chk("post_rst_lvl_end", 32'(fifo_level), 32'd0);
    chk("post_rst_tx_end", 32'(tx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
